ehl_deserializer: RTL and testbench
===================================

EHL_DESERIALIZER -- requirements
Module: ehl_deserializer

Interface
REQ-001 Parameter WIDTH, default 8, parallel word width in bits; legal range 2..64.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port flush  input  1  synchronous clear of the partial word; the held output word is kept.
REQ-005 Port sin  input  1  serial data bit.
REQ-006 Port sin_valid  input  1  sin carries a bit this cycle.
REQ-007 Port sin_ready  output  1  block accepts a bit this cycle; a bit transfers when sin_valid&&sin_ready.
REQ-008 Port dout  output  WIDTH  assembled word in arrival order: first bit received at dout[WIDTH-1], last at dout[0]; feeds the downstream bit-reversal stage.
REQ-009 Port dout_valid  output  1  dout holds a complete word.
REQ-010 Port dout_ready  input  1  consumer takes the word; a word transfers when dout_valid&&dout_ready.
REQ-011 Port parity_err  output  1  parity result for the current dout word.

Function
REQ-012 Datapath: one shift register (WIDTH bits) plus bit counter, and one output holding register.
REQ-013 Each accepted bit shifts in at the LSB; the counter increments from 0 to WIDTH-1.
REQ-014 On the accepted bit completing a word, the shift register moves to the holding register, dout_valid=1 next cycle, counter=0; latency last bit -> dout_valid = 1 cycle.
REQ-015 Completion while the holding register is full and not read this cycle: sin_ready=0 on that last bit; the bit is not accepted and no data is lost or overwritten.
REQ-016 sin_ready = !(counter==last_index && dout_valid && !dout_ready); combinational from state and dout_ready.
REQ-017 Simultaneous word completion and dout read: holding register reloads in the same cycle; dout_valid stays 1; back-to-back words need no idle cycle.
REQ-018 dout and parity_err remain stable while dout_valid=1 and dout_ready=0.
REQ-019 dout_valid deasserts the cycle after a read with no new word completed.
REQ-020 flush=1: counter=0, partial word discarded, sin ignored that cycle; holding register and dout_valid unaffected.
REQ-021 flush has priority over sin_valid; reset has priority over flush.
REQ-022 Without parity feature, parity_err is constant 0.

Reset
REQ-023 reset=1: counter=0, shift register=0, dout=0, dout_valid=0, parity_err=0; sin_ready=1 the cycle after release.
REQ-024 Reset mid-word or with a word held discards all data; no partial word is ever presented.

Configuration
REQ-025 Macro EHL_DESERIALIZER_PARITY_EN defined: each word is followed by one even-parity bit on sin; word completes on the parity bit (last_index=WIDTH); parity_err = XOR of WIDTH data bits and parity bit, registered with dout.
REQ-026 Macro undefined: no parity bit; last_index=WIDTH-1; parity_err=0; no parity logic synthesized.

Structure
REQ-027 Shared package ehl_pkg holds the counter-width function (clog2) used to size the bit counter.
REQ-028 One sub-module: ehl_deserializer_hold, the holding register with valid/ready handshake; everything else is flat.

Verification
REQ-029 WIDTH=8, bits 1,0,1,1,0,0,1,0 continuous, dout_ready=1 -> dout=8'hB2, dout_valid for 1 cycle, 1 cycle after bit 8.
REQ-030 Two words 8'hB2 then 8'h5C back-to-back, dout_ready=1 -> consecutive dout_valid, no sin_ready drop.
REQ-031 dout_ready=0, 8'hB2 held, 8 more bits offered -> sin_ready=0 on bit 8, dout stays 8'hB2; dout_ready=1 -> next word accepted, no loss.
REQ-032 flush after 3 bits, then 8'hA5 -> dout=8'hA5 only.
REQ-033 reset asserted after 5 bits and with a word held -> dout_valid=0, dout=0; next full word correct.
REQ-034 Parity enabled: 8'hB2 + parity 0 -> parity_err=0; 8'hB2 + parity 1 -> parity_err=1.

Source files
------------

// File: rtl/ehl_pkg.sv
// Shared definitions for the EHL deserializer: hold-register state encoding
// and the width helper used to size the bit counter.
package ehl_pkg;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

  // Bits needed to encode values 0..n-1; never less than 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/ehl_deserializer_hold.sv
// Output holding register with valid/ready handshake; a load may coincide
// with the consumer taking the current word.
module ehl_deserializer_hold
  import ehl_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         dout_ready,
  output logic [W-1:0] dout,
  output logic         dout_valid
);

  hold_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= HOLD_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD_EMPTY: if (load) state_d = HOLD_FULL;
      HOLD_FULL: begin
        if (load)            state_d = HOLD_FULL;
        else if (dout_ready) state_d = HOLD_EMPTY;
      end
      default: state_d = HOLD_EMPTY;
    endcase
  end

  // Upstream never loads while full and unread, so the word is never overwritten.
  always_ff @(posedge clk) begin
    if (reset)     dout <= '0;
    else if (load) dout <= din;
  end

  assign dout_valid = (state_q == HOLD_FULL);

endmodule

// File: rtl/ehl_deserializer.sv
// Serial-to-parallel deserializer: first bit lands in dout[WIDTH-1].
// Optional trailing even-parity bit per word enabled by EHL_DESERIALIZER_PARITY_EN.
module ehl_deserializer
  import ehl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             sin_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             parity_err
);

`ifdef EHL_DESERIALIZER_PARITY_EN
  localparam int unsigned LAST_IDX = WIDTH;
  localparam int unsigned SH_W     = WIDTH;
  localparam int unsigned HOLD_W   = WIDTH + 1;
`else
  localparam int unsigned LAST_IDX = WIDTH - 1;
  localparam int unsigned SH_W     = WIDTH - 1;
  localparam int unsigned HOLD_W   = WIDTH;
`endif
  localparam int unsigned CNT_W = clog2(LAST_IDX + 1);

  logic [CNT_W-1:0]  cnt_q;
  logic [SH_W-1:0]   shreg_q;
  logic [HOLD_W-1:0] word;
  logic [HOLD_W-1:0] hold_dout;
  logic              at_last;
  logic              accept;
  logic              complete;

  assign at_last   = (cnt_q == CNT_W'(LAST_IDX));
  assign sin_ready = !(at_last && dout_valid && !dout_ready);
  assign accept    = sin_valid && sin_ready && !flush;
  assign complete  = accept && at_last;

`ifdef EHL_DESERIALIZER_PARITY_EN
  logic par_q;

  // Running XOR of data bits; the parity bit itself closes the word.
  always_ff @(posedge clk) begin
    if (reset || flush)        par_q <= 1'b0;
    else if (complete)         par_q <= 1'b0;
    else if (accept)           par_q <= par_q ^ sin;
  end

  assign word       = {par_q ^ sin, shreg_q};
  assign dout       = hold_dout[WIDTH-1:0];
  assign parity_err = hold_dout[WIDTH];
`else
  // Last data bit goes straight into the word without passing the shifter.
  assign word       = {shreg_q, sin};
  assign dout       = hold_dout;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else if (complete) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else if (accept) begin
      cnt_q   <= cnt_q + CNT_W'(1);
      shreg_q <= SH_W'({shreg_q, sin});
    end
  end

  ehl_deserializer_hold #(
    .W (HOLD_W)
  ) u_hold (
    .clk        (clk),
    .reset      (reset),
    .load       (complete),
    .din        (word),
    .dout_ready (dout_ready),
    .dout       (hold_dout),
    .dout_valid (dout_valid)
  );

endmodule

// File: tb/tb_ehl_deserializer.sv
// Self-checking bench for ehl_deserializer: directed scenarios plus random
// traffic against a bit-queue reference model.
module tb_ehl_deserializer;

  localparam int unsigned WIDTH = 8;
`ifdef EHL_DESERIALIZER_PARITY_EN
  localparam int unsigned NB  = WIDTH + 1;
  localparam bit          PAR = 1'b1;
`else
  localparam int unsigned NB  = WIDTH;
  localparam bit          PAR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, flush, sin, sin_valid, dout_ready;
  logic             sin_ready, dout_valid, parity_err;
  logic [WIDTH-1:0] dout;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: pending bits, held word, held parity flag, held valid.
  bit               bq[$];
  logic [WIDTH-1:0] hw;
  logic             hp;
  bit               hv;

  always #5 clk = ~clk;

  ehl_deserializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sin_ready  (sin_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .parity_err (parity_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, advance both.
  task automatic step(input logic r, input logic f, input logic v, input logic s, input logic dr);
    logic             er, rd, p;
    logic [WIDTH-1:0] w;
    reset = r; flush = f; sin_valid = v; sin = s; dout_ready = dr;
    #1;
    er = !((bq.size() == NB - 1) && hv && !dr);
    chk("sin_ready", 64'(sin_ready), 64'(er));
    chk("dout_valid", 64'(dout_valid), 64'(hv));
    if (hv) begin
      chk("dout", 64'(dout), 64'(hw));
      chk("parity_err", 64'(parity_err), 64'(hp));
    end
    rd = hv && dr;
    @(posedge clk);
    #1;
    if (r) begin
      bq.delete(); hv = 1'b0; hw = '0; hp = 1'b0;
    end else begin
      if (rd) hv = 1'b0;
      if (f) bq.delete();
      else if (v && er) begin
        bq.push_back(s);
        if (bq.size() == NB) begin
          w = '0; p = 1'b0;
          for (int i = 0; i < WIDTH; i++) w = {w[WIDTH-2:0], logic'(bq[i])};
          foreach (bq[k]) p = p ^ bq[k];
          hw = w; hp = PAR ? p : 1'b0; hv = 1'b1;
          bq.delete();
        end
      end
    end
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input logic pbit, input logic dr);
    for (int i = WIDTH - 1; i >= 0; i--) step(1'b0, 1'b0, 1'b1, w[i], dr);
    if (PAR) step(1'b0, 1'b0, 1'b1, pbit, dr);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; sin = 1'b0; sin_valid = 1'b0; dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    bq.delete(); hv = 1'b0; hw = '0; hp = 1'b0;
    #1;
    chk("rst_dout_valid", 64'(dout_valid), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_parity_err", 64'(parity_err), 64'd0);
    chk("rst_sin_ready", 64'(sin_ready), 64'd1);

    // Single word B2, one-cycle valid
    send_word(8'hB2, 1'b0, 1'b1);
    chk("b2_valid", 64'(dout_valid), 64'd1);
    chk("b2_dout", 64'(dout), 64'hB2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("b2_valid_drop", 64'(dout_valid), 64'd0);

    // Back-to-back B2, 5C
    send_word(8'hB2, 1'b0, 1'b1);
    send_word(8'h5C, 1'b0, 1'b1);
    chk("b2b_valid", 64'(dout_valid), 64'd1);
    chk("b2b_dout", 64'(dout), 64'h5C);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure: last bit of second word stalls while B2 held
    send_word(8'hB2, 1'b0, 1'b0);
    for (int i = WIDTH - 1; i >= 1; i--) step(1'b0, 1'b0, 1'b1, i[0], 1'b0);
    if (PAR) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    sin_valid = 1'b1; sin = 1'b0; dout_ready = 1'b0;
    #1;
    chk("bp_sin_ready", 64'(sin_ready), 64'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("bp_hold_dout", 64'(dout), 64'hB2);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("bp_next_dout", 64'(dout), 64'hAA);
    chk("bp_next_valid", 64'(dout_valid), 64'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Flush after three bits, then A5
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    send_word(8'hA5, 1'b0, 1'b1);
    chk("flush_dout", 64'(dout), 64'hA5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-word and with a word held
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    do_reset();
    chk("rst_mid_valid", 64'(dout_valid), 64'd0);
    send_word(8'h3C, 1'b0, 1'b0);
    do_reset();
    chk("rst_held_valid", 64'(dout_valid), 64'd0);
    chk("rst_held_dout", 64'(dout), 64'd0);
    send_word(8'h96, 1'b1, 1'b1);
    chk("post_rst_dout", 64'(dout), 64'h96);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef EHL_DESERIALIZER_PARITY_EN
    send_word(8'hB2, 1'b0, 1'b1);
    chk("par_ok", 64'(parity_err), 64'd0);
    send_word(8'hB2, 1'b1, 1'b1);
    chk("par_err", 64'(parity_err), 64'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step(logic'($urandom_range(0, 499) == 0),
           logic'($urandom_range(0, 49) == 0),
           logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
